ps2_key_source: RTL and testbench
=================================

# ps2_key_source

Producer end of the `keycode`/`keystrobe` handshake that the game top consumes. The block receives PS/2 set-2 scancode frames from a keyboard, drops release codes, and translates the mapped make codes to 7-bit ASCII. It buffers up to four keys and presents them as `keycode = {valid, ascii}`. It sits between the board PS/2 pins and the game top's `keycode`/`keystrobe` ports.

## Interface
- `TIMEOUT_CYCLES`, default 2500: maximum clk cycles between ps2_clk falling edges inside a frame before the frame is abandoned.
- `FIFO_DEPTH`, default 4: key buffer depth; must be a power of two.
- `clk`  input  1  system clock; all logic on its rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `ps2_clk`  input  1  raw PS/2 clock, asynchronous.
- `ps2_data`  input  1  raw PS/2 data, asynchronous.
- `keycode`  output  8  bit 7 is valid; bits 6:0 are ASCII. Equals 8'h00 when no key is pending.
- `keystrobe`  input  1  consumer acknowledge; pops the head key.
- `frame_err`  output  1  one-cycle pulse on a bad start bit, parity, stop bit, or timeout.
- `overflow`  output  1  sticky; set when a key is dropped because the FIFO is full. Cleared only by reset.

## Operation
- **Input sampling**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - A falling edge is detected as previous synchronized value = 1 and current = 0.
  - Data is sampled only on detected falling edges.
- **Frame FSM**
  - States: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data = 0, go to DATA and clear the bit count. An edge with data = 1 is a bad start bit: pulse `frame_err` and stay in IDLE.
  - DATA: shift 8 bits LSB-first; after the 8th bit go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: if stop = 1 and the parity is odd over data plus parity bit, emit the byte. Otherwise pulse `frame_err`. Return to IDLE in both cases.
  - Timeout counter: reset on every edge and in IDLE. When it reaches `TIMEOUT_CYCLES` in any non-IDLE state, return to IDLE and pulse `frame_err`.
- **Scancode decoder** (flags `ext`, `brk`)
  - Byte E0: set `ext`.
  - Byte F0: set `brk`.
  - Any other byte:
    - If `brk` is set, discard the byte.
    - Otherwise look it up using `ext` to choose the table.
    - Clear both flags afterwards.
  - Plain codes: 1D→'w' (0x77), 1B→'s' (0x73), 1C→'a' (0x61), 23→'d' (0x64), 29→0x20, 5A→0x0D, 76→0x1B.
  - Extended codes: 75→'w', 72→'s', 6B→'a', 74→'d'.
  - Unmapped codes are dropped silently.
  - A frame error clears `ext` and `brk`.
- **FIFO**
  - Depth `FIFO_DEPTH`. Pointers are one bit wider than the address and wrap naturally.
  - `keycode` = {1, head} when not empty, else 8'h00.
  - A pop occurs on any cycle with `keystrobe` = 1 and not empty.
  - A held-high `keystrobe` therefore drains one key per cycle.
- **Boundary cases**
  - Push while full and no pop: the key is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: both occur and nothing is dropped.
  - Push and pop in the same cycle while empty: no pop occurs. The new key appears on `keycode` the next cycle.
  - `keystrobe` while empty: ignored.

## Timing
- **Reset values** (synchronous reset, `reset` = 0)
  - FSM in IDLE, flags clear, FIFO empty, timeout counter 0.
  - `keycode` = 0, `frame_err` = 0, `overflow` = 0.
  - Reset asserted mid-frame abandons the frame without a `frame_err` pulse.
- **Latency**
  - Edge detection: 3 clk cycles after the raw `ps2_clk` falls.
  - Emitted byte: decoded and pushed 1 cycle after the stop-bit edge is detected.
  - `keycode` shows the key 1 cycle after the push, when the FIFO was empty.
- **Consumer-side timing**
  - `keycode` updates to the next entry, or to 0, the cycle after a pop.
  - `frame_err` pulses on the cycle the FSM returns to IDLE because of the error.

## Structure
- Shared constants go in `enums.vh` as `define`s:
  - scancode values (E0, F0, and mapped codes);
  - ASCII outputs;
  - frame FSM state encodings.
- Natural sub-module: `ps2_frame_rx`, containing the synchronizer, edge detect, frame FSM and timeout. It outputs `byte_valid`, `byte_data` and `frame_err`.
- The top level holds the decoder flags, the lookup, and the FIFO.

## Test plan
- Frames 1D, then F0 1D; `keystrobe` held at 0 → `keycode` = 8'hF7 and stays there; the release sequence adds no entry.
- Frames E0 6B with `keystrobe` pulsed one cycle after valid → `keycode` = 8'hE1, then 8'h00 the following cycle.
- Frame with even parity for byte 1C → one-cycle `frame_err`, `keycode` stays 8'h00. A following good 23 frame → 8'hE4.
- Six make codes (1D 1B 1C 23 29 5A) with `keystrobe` = 0 → first four buffered, `overflow` = 1. With `keystrobe` held high: F7, F3, E1, E4 on consecutive cycles, then 00.
- Stop toggling `ps2_clk` after 4 data bits for `TIMEOUT_CYCLES` → `frame_err` pulse, FSM in IDLE. A following full 1B frame → 8'hF3.
- Assert `reset` = 0 mid-frame with two keys buffered → next cycle `keycode` = 0, `overflow` = 0, no `frame_err`. A following 1C frame decodes to 8'hE1.

Source files
------------

// File: rtl/ps2_key_source_pkg.sv
// rtl/ps2_key_source_pkg.sv - shared scancodes, ASCII codes, frame states and key lookup
package ps2_key_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_BRK     = 8'hF0;
    localparam logic [7:0] SC_W       = 8'h1D;
    localparam logic [7:0] SC_S       = 8'h1B;
    localparam logic [7:0] SC_A       = 8'h1C;
    localparam logic [7:0] SC_D       = 8'h23;
    localparam logic [7:0] SC_SPACE   = 8'h29;
    localparam logic [7:0] SC_ENTER   = 8'h5A;
    localparam logic [7:0] SC_ESC     = 8'h76;
    localparam logic [7:0] SC_X_UP    = 8'h75;
    localparam logic [7:0] SC_X_DOWN  = 8'h72;
    localparam logic [7:0] SC_X_LEFT  = 8'h6B;
    localparam logic [7:0] SC_X_RIGHT = 8'h74;

    localparam logic [6:0] ASC_W     = 7'h77;
    localparam logic [6:0] ASC_S     = 7'h73;
    localparam logic [6:0] ASC_A     = 7'h61;
    localparam logic [6:0] ASC_D     = 7'h64;
    localparam logic [6:0] ASC_SPACE = 7'h20;
    localparam logic [6:0] ASC_CR    = 7'h0D;
    localparam logic [6:0] ASC_ESC   = 7'h1B;

    // Returns {hit, ascii}; hit = 0 means the code is not mapped.
    function automatic logic [7:0] lookup_key(input logic ext, input logic [7:0] code);
        logic [7:0] r;
        r = 8'h00;
        if (ext) begin
            case (code)
                SC_X_UP:    r = {1'b1, ASC_W};
                SC_X_DOWN:  r = {1'b1, ASC_S};
                SC_X_LEFT:  r = {1'b1, ASC_A};
                SC_X_RIGHT: r = {1'b1, ASC_D};
                default:    r = 8'h00;
            endcase
        end else begin
            case (code)
                SC_W:     r = {1'b1, ASC_W};
                SC_S:     r = {1'b1, ASC_S};
                SC_A:     r = {1'b1, ASC_A};
                SC_D:     r = {1'b1, ASC_D};
                SC_SPACE: r = {1'b1, ASC_SPACE};
                SC_ENTER: r = {1'b1, ASC_CR};
                SC_ESC:   r = {1'b1, ASC_ESC};
                default:  r = 8'h00;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_key_source_frame_rx.sv
// rtl/ps2_key_source_frame_rx.sv - PS/2 pin synchronizer, falling-edge detect and frame FSM
module ps2_frame_rx
    import ps2_key_source_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]   clk_sync;
    logic [1:0]   data_sync;
    logic         fall;
    logic         sdata;
    frame_state_t state;
    logic [2:0]   bit_cnt;
    logic [7:0]   shreg;
    logic         par;
    logic [TW-1:0] timer;

    // Bit 2 is the previous synchronized clock, used only for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall  = clk_sync[2] & ~clk_sync[1];
    assign sdata = data_sync[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par        <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                timer <= '0;
                case (state)
                    ST_IDLE: begin
                        if (!sdata) begin
                            state   <= ST_DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {sdata, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par   <= sdata;
                        state <= ST_STOP;
                    end
                    default: begin
                        if (sdata && (^{shreg, par})) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state == ST_IDLE) begin
                timer <= '0;
            end else if (timer == TW'(TIMEOUT_CYCLES)) begin
                state     <= ST_IDLE;
                frame_err <= 1'b1;
                timer     <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_key_source.sv
// rtl/ps2_key_source.sv - PS/2 make-code to ASCII translator with key FIFO
module ps2_key_source
    import ps2_key_source_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2500,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    input  logic       keystrobe,
    output logic       frame_err,
    output logic       overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       ext;
    logic       brk;
    logic [7:0] lk;
    logic       is_prefix;
    logic       push;
    logic       pop;
    logic       empty;
    logic       full;
    logic       wr_en;
    logic [6:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign lk        = lookup_key(ext, byte_data);
    assign is_prefix = (byte_data == SC_EXT) || (byte_data == SC_BRK);
    assign push      = byte_valid && !is_prefix && !brk && lk[7];

    always_ff @(posedge clk) begin
        if (!reset) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (frame_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_valid) begin
            if (byte_data == SC_EXT) begin
                ext <= 1'b1;
            end else if (byte_data == SC_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = keystrobe && !empty;
    // A simultaneous pop frees the head slot, so a full FIFO can still accept.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= lk[6:0];
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    assign keycode = empty ? 8'h00 : {1'b1, mem[rd_ptr[AW-1:0]]};

endmodule

// File: tb/tb_ps2_key_source.sv
// tb/tb_ps2_key_source.sv - scoreboard bench for ps2_key_source
module tb_ps2_key_source;

    localparam int TIMEOUT = 2500;
    localparam int HALF    = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       keystrobe = 1'b0;
    logic [7:0] keycode;
    logic       frame_err;
    logic       overflow;

    int checks = 0;
    int fails  = 0;
    int err_count = 0;

    logic [7:0] exp_q[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_ovf = 1'b0;

    ps2_key_source #(.TIMEOUT_CYCLES(TIMEOUT), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keycode   (keycode),
        .keystrobe (keystrobe),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) err_count++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_lookup(input logic e, input logic [7:0] c);
        logic [7:0] r;
        r = 8'h00;
        if (!e) begin
            case (c)
                8'h1D: r = 8'hF7;
                8'h1B: r = 8'hF3;
                8'h1C: r = 8'hE1;
                8'h23: r = 8'hE4;
                8'h29: r = 8'hA0;
                8'h5A: r = 8'h8D;
                8'h76: r = 8'h9B;
                default: r = 8'h00;
            endcase
        end else begin
            case (c)
                8'h75: r = 8'hF7;
                8'h72: r = 8'hF3;
                8'h6B: r = 8'hE1;
                8'h74: r = 8'hE4;
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] k;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (!m_brk) begin
                k = model_lookup(m_ext, b);
                if (k != 8'h00) begin
                    if (exp_q.size() < 4) exp_q.push_back(k);
                    else m_ovf = 1'b1;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bits(frame_bits(b, bad_par), 11);
        ps2_data = 1'b1;
        repeat (6) @(negedge clk);
        if (bad_par) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else begin
            model_byte(b);
        end
    endtask

    task automatic wait_key(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (keycode[7]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (keycode !== 8'h00) begin fails++; $display("FAIL reset_keycode: got %h want 00", keycode); end
        checks++;
        if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++;
        if (keycode !== 8'h00) begin fails++; $display("FAIL post_reset_keycode: got %h want 00", keycode); end
    endtask

    task automatic test_release;
        logic ok;
        logic [7:0] e;
        send_frame(8'h1D, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        wait_key(ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL release_wait: keycode %h never valid", keycode); end
        repeat (20) @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (keycode !== e) begin fails++; $display("FAIL release_key: got %h want %h", keycode, e); end
        keystrobe = 1'b1;
        @(negedge clk);
        keystrobe = 1'b0;
        e = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        checks++;
        if (keycode !== e) begin fails++; $display("FAIL release_no_extra: got %h want %h", keycode, e); end
    endtask

    task automatic test_extended;
        logic ok;
        logic [7:0] e;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        wait_key(ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL ext_wait: keycode %h never valid", keycode); end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (keycode !== e) begin fails++; $display("FAIL ext_key: got %h want %h", keycode, e); end
        keystrobe = 1'b1;
        @(negedge clk);
        keystrobe = 1'b0;
        checks++;
        if (keycode !== 8'h00) begin fails++; $display("FAIL ext_popped: got %h want 00", keycode); end
    endtask

    task automatic test_parity;
        logic ok;
        logic [7:0] e;
        int e0;
        e0 = err_count;
        send_frame(8'h1C, 1'b1);
        checks++;
        if (err_count - e0 !== 1) begin fails++; $display("FAIL parity_err: got %0d pulses want 1", err_count - e0); end
        checks++;
        if (keycode !== 8'h00) begin fails++; $display("FAIL parity_keycode: got %h want 00", keycode); end
        send_frame(8'h23, 1'b0);
        wait_key(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || keycode !== e) begin fails++; $display("FAIL parity_next_key: got %h want %h", keycode, e); end
        keystrobe = 1'b1;
        @(negedge clk);
        keystrobe = 1'b0;
    endtask

    task automatic test_overflow;
        logic [7:0] codes [6];
        logic [7:0] e;
        codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h5A};
        foreach (codes[i]) send_frame(codes[i], 1'b0);
        @(negedge clk);
        checks++;
        if (overflow !== m_ovf) begin fails++; $display("FAIL overflow_flag: got %b want %b", overflow, m_ovf); end
        e = exp_q.pop_front();
        checks++;
        if (keycode !== e) begin fails++; $display("FAIL drain_0: got %h want %h", keycode, e); end
        keystrobe = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (keycode !== e) begin fails++; $display("FAIL drain_%0d: got %h want %h", i, keycode, e); end
        end
        @(negedge clk);
        checks++;
        if (keycode !== 8'h00) begin fails++; $display("FAIL drain_empty: got %h want 00", keycode); end
        keystrobe = 1'b0;
    endtask

    task automatic test_timeout;
        logic ok;
        logic [7:0] e;
        int e0;
        e0 = err_count;
        send_bits(frame_bits(8'h1B, 1'b0), 5);
        ps2_data = 1'b1;
        for (int i = 0; i < TIMEOUT + 400; i++) begin
            if (err_count != e0) break;
            @(negedge clk);
        end
        checks++;
        if (err_count - e0 !== 1) begin fails++; $display("FAIL timeout_err: got %0d pulses want 1", err_count - e0); end
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h1B, 1'b0);
        wait_key(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || keycode !== e) begin fails++; $display("FAIL timeout_next_key: got %h want %h", keycode, e); end
        keystrobe = 1'b1;
        @(negedge clk);
        keystrobe = 1'b0;
    endtask

    task automatic test_reset_midframe;
        logic ok;
        logic [7:0] e;
        int e0;
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1B, 1'b0);
        send_bits(frame_bits(8'h5A, 1'b0), 3);
        e0 = err_count;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (keycode !== 8'h00) begin fails++; $display("FAIL midreset_keycode: got %h want 00", keycode); end
        checks++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL midreset_overflow: got %b want 0", overflow); end
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_ovf = 1'b0;
        reset = 1'b1;
        ps2_data = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (err_count - e0 !== 0) begin fails++; $display("FAIL midreset_no_err: got %0d pulses want 0", err_count - e0); end
        send_frame(8'h1C, 1'b0);
        wait_key(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || keycode !== e) begin fails++; $display("FAIL midreset_next_key: got %h want %h", keycode, e); end
    endtask

    initial begin
        test_reset();
        test_release();
        test_extended();
        test_parity();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
